// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider producing one quotient bit per
// clock. Signed operation divides the magnitudes and then fixes up the signs,
// so quotients truncate toward zero and the remainder follows the dividend.
//
// Handshake: start is a request sampled only while the block is idle. There is
// no ready output; busy=1 means a request will be ignored. done is a one-cycle
// pulse, and quotient/remainder/div_by_zero are valid from the done cycle
// until the next accepted start overwrites them.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             sign_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic [1:0]       dbg_state
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;       // partial remainder, one guard bit
   logic [WIDTH-1:0] quo_q, quo_d;       // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
   logic [CW-1:0]    cnt_q, cnt_d;       // iterations completed
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] dd_abs;
   logic [WIDTH-1:0] ds_abs;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic             trial_neg;

   // Operand magnitudes; -2^(WIDTH-1) maps onto itself, which is the correct
   // unsigned magnitude.
   assign dd_abs = (sign_mode && dividend[WIDTH-1]) ? -dividend : dividend;
   assign ds_abs = (sign_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

   // One restoring step: shift the next dividend bit in and try a subtract.
   assign shifted   = {rem_q, quo_q[WIDTH-1]};
   assign trial     = shifted - {2'b00, dvs_q};
   assign trial_neg = trial[WIDTH+1];

   // State and datapath registers; clear zeroes everything and aborts.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   // Next-state and datapath updates for capture, iterate and sign fix-up.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvs_d   = ds_abs;
               quo_d   = dd_abs;
               rem_d   = '0;
               cnt_d   = '0;
               q_neg_d = sign_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               r_neg_d = sign_mode & dividend[WIDTH-1];
               dbz_d   = 1'b0;
               if (divisor == '0) begin
                  // Results are known immediately; skip straight to DONE.
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  state_d = S_ITER;
               end
            end
         end
         S_ITER: begin
            rem_d = trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial_neg};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quotient_d  = q_neg_q ? -quo_q : quo_q;
            remainder_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            state_d     = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with hand-computed expected results.
module tb_seq_divider;

   logic        clock;
   logic        clear;
   logic        start;
   logic        sign_mode;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .sign_mode   (sign_mode),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .quotient    (quotient),
      .remainder   (remainder),
      .dbg_state   (dbg_state)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one divide and follow it to completion with a bounded wait on done.
   task automatic run_div(input string tag, input logic sm, input logic [31:0] dd,
                          input logic [31:0] ds, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_dbz,
                          input int exp_lat);
      int n;
      sign_mode = sm;
      dividend  = dd;
      divisor   = ds;
      start     = 1'b1;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_quo"}, quotient, exp_q);
      check({tag, "_rem"}, remainder, exp_r);
      check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
      tick();
      check({tag, "_done_low"}, {31'b0, done}, 32'd0);
      check({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int done_seen;
      clear     = 1'b1;
      start     = 1'b0;
      sign_mode = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) tick();
      clear = 1'b0;

      // Reset state
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
      check("rst_quo", quotient, 32'd0);
      check("rst_rem", remainder, 32'd0);
      check("rst_state", {30'b0, dbg_state}, 32'd0);

      // Main function: 22069/51 = 432 r 37
      run_div("u_5635", 1'b0, 32'h0000_5635, 32'h0000_0033, 32'h0000_01B0, 32'h0000_0025, 1'b0, 33);
      run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
      run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0, 33);
      run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33);

      // Divide by zero completes at the capture edge.
      run_div("dbz", 1'b0, 32'h0000_0018, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0018, 1'b1, 0);
      run_div("u_6_3", 1'b0, 32'h0000_0006, 32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 1'b0, 33);

      // start while busy (ITER, FIX and DONE) is ignored: 100/7 = 14 r 2.
      sign_mode = 1'b0;
      dividend  = 32'd100;
      divisor   = 32'd7;
      start     = 1'b1;
      tick();                       // edge 0
      start = 1'b0;
      repeat (4) tick();            // edges 1..4
      dividend = 32'd5;
      divisor  = 32'd1;
      start    = 1'b1;
      tick();                       // edge 5
      start = 1'b0;
      repeat (27) tick();           // edges 6..32
      dividend = 32'd9;
      divisor  = 32'd0;
      start    = 1'b1;
      tick();                       // edge 33
      check("ign_done", {31'b0, done}, 32'd1);
      check("ign_quo", quotient, 32'd14);
      check("ign_rem", remainder, 32'd2);
      tick();                       // edge 34, start still high in DONE
      start = 1'b0;
      check("ign_done_low", {31'b0, done}, 32'd0);
      check("ign_idle", {31'b0, busy}, 32'd0);
      tick();
      check("ign_hold_quo", quotient, 32'd14);
      check("ign_hold_dbz", {31'b0, div_by_zero}, 32'd0);

      // clear at edge 10 aborts the operation.
      sign_mode = 1'b1;
      dividend  = 32'd1000;
      divisor   = 32'd10;
      start     = 1'b1;
      tick();                       // edge 0
      start = 1'b0;
      repeat (9) tick();            // edges 1..9
      clear = 1'b1;
      tick();                       // edge 10
      clear = 1'b0;
      check("clr_busy", {31'b0, busy}, 32'd0);
      check("clr_done", {31'b0, done}, 32'd0);
      check("clr_dbz", {31'b0, div_by_zero}, 32'd0);
      check("clr_quo", quotient, 32'd0);
      check("clr_rem", remainder, 32'd0);
      check("clr_state", {30'b0, dbg_state}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) done_seen++;
      end
      check("clr_no_done", done_seen, 32'd0);

      // Fresh divide after the abort: -1000/7 = -142 r -6.
      run_div("s_m1000_7", 1'b1, 32'hFFFF_FC18, 32'h0000_0007, 32'hFFFF_FF72, 32'hFFFF_FFFA, 1'b0, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider that sits behind the ALU as the responder to the control unit's DIV step. The control sequence drives the dividend from Y and the divisor from the bus, then pulses `start`. The block iterates one quotient bit per clock. It returns the quotient for Zlow and the remainder for Zhigh, with a `done` pulse so the sequencer can advance to the Zlowout/Zhighout steps.

## Interface
- WIDTH, 32, operand/result width; latency scales as WIDTH+2

- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sign_mode  in  1  1 = two's-complement signed divide, 0 = unsigned; sampled with start
- dividend  in  WIDTH  numerator (Y register); sampled with start
- divisor  in  WIDTH  denominator (bus); sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  high exactly one cycle, while state == DONE
- div_by_zero  out  1  registered; set when the captured divisor was 0, cleared at next accepted start
- quotient  out  WIDTH  registered result for Zlow
- remainder  out  WIDTH  registered result for Zhigh

## Operation
- States: IDLE, ITER, FIX, DONE. `busy` and `done` decode directly from the state register.
- IDLE with start=1 (edge 0):
  - Capture magnitudes |dividend| and |divisor|. Absolute value applies only if sign_mode=1.
  - Capture sign flags: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend).
  - Clear `div_by_zero`. Set count=0 and rem=0 (WIDTH+1 bits); quo = |dividend|.
  - If divisor == 0: next state is DONE. quotient <= all ones, remainder <= dividend (raw), div_by_zero <= 1.
  - Otherwise: next state is ITER.
- ITER, once per clock:
  - Shift {rem,quo} left by 1.
  - trial = rem_shifted − {0,|divisor|}.
  - If trial ≥ 0: rem = trial and quo[0] = 1; else quo[0] = 0.
  - count increments. After WIDTH iterations, next state is FIX.
- FIX:
  - quotient <= q_neg ? −quo : quo.
  - remainder <= r_neg ? −rem[WIDTH-1:0] : rem[WIDTH-1:0].
  - Next state is DONE.
- DONE: one cycle, then IDLE.
- Arithmetic rules:
  - Signed results truncate toward zero; the remainder takes the sign of the dividend.
  - Magnitude of −2^(WIDTH−1) is handled as unsigned WIDTH bits.
  - Overflow case (−2^31 / −1) yields quotient 0x8000_0000, remainder 0, with no flag.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next operation writes them. Inputs are ignored outside the capture edge.
- `start` while busy (including the DONE cycle) is ignored; no queuing.
- clear=1 at any clock edge:
  - state <= IDLE; busy, done, div_by_zero, quotient, remainder, count, rem, quo all <= 0.
  - Aborts any operation in flight; no done pulse is produced.
  - clear has priority over start on the same edge.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
- Normal divide, with edge 0 = the start-capture edge:
  - Edges 1..WIDTH run ITER; edge WIDTH+1 runs FIX and writes the results.
  - `done`=1 from edge WIDTH+1 to edge WIDTH+2 (edges 33–34 for WIDTH=32).
  - `busy`=1 from edge 0 to edge WIDTH+2.
  - Results are valid while done=1 and after.
- Divide by zero: results written at edge 0; done=1 from edge 0 to edge 1; busy=1 for that single cycle.
- Back-to-back: the earliest next accepted start is the first edge with state == IDLE, i.e. edge WIDTH+2. Throughput is one divide per WIDTH+2 cycles.
- No combinational path from any input to any output.

## Test plan
- Unsigned 0x0000_5635 / 0x0000_0033 -> at edge 33: quotient 0x0000_01B0, remainder 0x0000_0025; done high exactly one cycle; div_by_zero=0.
- Signed −7/2 (0xFFFF_FFF9, 0x0000_0002) -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF.
- Same operands unsigned -> quotient 0x7FFF_FFFC, remainder 0x0000_0001.
- Signed 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0.
- Divisor 0 with dividend 0x18 -> done one cycle after start; quotient 0xFFFF_FFFF, remainder 0x18, div_by_zero=1. A following 6/3 (quotient 2, remainder 0) clears div_by_zero.
- Start pulsed with different operands at edges 5 and 33 of an operation -> both ignored, original result produced. clear at edge 10 of a new divide -> all outputs 0 next cycle and no done pulse; a fresh start afterwards completes normally.
